// File: rtl/cell_tx_scheduler.sv
// -----------------------------------------------------------------------------
// cell_tx_scheduler
//
// Purpose:
//    Shares one outbound 32-bit AXI-Stream link (towards the Aurora core) among
//    NUM_REQ local requesters, one packet at a time. A packet is one header word
//    (magic number + requester index) followed by NUM_DATA_WORDS data words.
//    Grants rotate round-robin and each requester is served at most once per
//    distribution cycle, which is delimited by newCycleStrobe.
//
// Ports:
//    auroraClk            sole clock
//    auroraReset          synchronous, active-high reset
//    newCycleStrobe       one-cycle pulse starting a new distribution cycle
//    expectedHeaderMagic  magic value written into every header
//    reqValid             per-requester "packet pending"
//    reqIndex             flattened per-requester index, INDEX_WIDTH bits each
//    reqData              flattened per-requester payload, NUM_DATA_WORDS words each
//    reqAck               one-cycle pulse: that requester's index/data were captured
//    TVALID/TREADY/TLAST/TDATA  AXI-Stream master towards the link
//    sentMask             requesters already served in the current cycle
//    cycleDoneStrobe      one-cycle pulse when sentMask becomes all ones
//    packetCount          packets completed since reset (wraps)
// -----------------------------------------------------------------------------
module cell_tx_scheduler #(
   parameter int NUM_REQ         = 4,
   parameter int MAGIC_WIDTH     = 16,
   parameter int MAGIC_START_BIT = 16,
   parameter int INDEX_WIDTH     = 5,
   parameter int INDEX_START_BIT = 10,
   parameter int NUM_DATA_WORDS  = 1
) (
   input  logic                               auroraClk,
   input  logic                               auroraReset,
   input  logic                               newCycleStrobe,
   input  logic [MAGIC_WIDTH-1:0]             expectedHeaderMagic,
   input  logic [NUM_REQ-1:0]                 reqValid,
   input  logic [NUM_REQ*INDEX_WIDTH-1:0]     reqIndex,
   input  logic [NUM_REQ*32*NUM_DATA_WORDS-1:0] reqData,
   output logic [NUM_REQ-1:0]                 reqAck,
   output logic                               TVALID,
   input  logic                               TREADY,
   output logic                               TLAST,
   output logic [31:0]                        TDATA,
   output logic [NUM_REQ-1:0]                 sentMask,
   output logic                               cycleDoneStrobe,
   output logic [15:0]                        packetCount
);

   localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W  = (NUM_DATA_WORDS > 1) ? $clog2(NUM_DATA_WORDS) : 1;
   localparam int DATA_W = 32 * NUM_DATA_WORDS;

   // Parameter sanity: reject configurations that would build a malformed
   // header or a packet without payload.
   if (NUM_REQ < 2) begin : gBadNumReq
      $error("cell_tx_scheduler: NUM_REQ must be at least 2");
   end
   if (NUM_DATA_WORDS < 1) begin : gBadDataWords
      $error("cell_tx_scheduler: NUM_DATA_WORDS must be at least 1");
   end
   if ((INDEX_START_BIT <= MAGIC_START_BIT + MAGIC_WIDTH - 1) &&
       (MAGIC_START_BIT <= INDEX_START_BIT + INDEX_WIDTH - 1)) begin : gFieldOverlap
      $error("cell_tx_scheduler: header index field overlaps magic field");
   end
   if ((MAGIC_START_BIT + MAGIC_WIDTH > 32) ||
       (INDEX_START_BIT + INDEX_WIDTH > 32)) begin : gFieldRange
      $error("cell_tx_scheduler: header field exceeds 32 bits");
   end

   typedef enum logic [1:0] {
      S_IDLE,
      S_HEADER,
      S_DATA
   } StateType;

   StateType                 state, stateNext;
   logic [PTR_W-1:0]         rrPtr, rrPtrNext;
   logic [PTR_W-1:0]         grantId, grantIdNext;
   logic [CNT_W-1:0]         wordCnt, wordCntNext;
   logic [DATA_W-1:0]        dataLatch, dataLatchNext;
   logic                     tvalidNext, tlastNext;
   logic [31:0]              tdataNext;
   logic [NUM_REQ-1:0]       reqAckNext, sentMaskNext;
   logic                     cycleDoneNext;
   logic [15:0]              packetCountNext;

   logic [NUM_REQ-1:0]       eligible;
   logic                     grantFound;
   logic [PTR_W-1:0]         grantSel;
   int                       candIdx;
   logic [INDEX_WIDTH-1:0]   selIndex;
   logic [DATA_W-1:0]        selData;
   logic [31:0]              header;
   logic [31:0]              nextWord;
   logic                     nextIsLast;
   logic                     handshake;

   assign eligible  = reqValid & ~sentMask;
   assign handshake = TVALID && TREADY;

   // Round-robin search: walk upward from rrPtr, wrapping at NUM_REQ, and take
   // the first requester that still has a packet and has not been served yet.
   always_comb begin
      grantFound = 1'b0;
      grantSel   = '0;
      candIdx    = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         candIdx = int'(rrPtr) + i;
         if (candIdx >= NUM_REQ) begin
            candIdx = candIdx - NUM_REQ;
         end
         if (!grantFound && eligible[PTR_W'(candIdx)]) begin
            grantFound = 1'b1;
            grantSel   = PTR_W'(candIdx);
         end
      end
   end

   // Pick out the winner's index and payload and build the header word; all
   // header bits outside the magic and index fields stay zero.
   always_comb begin
      selIndex = '0;
      selData  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (grantSel == PTR_W'(k)) begin
            selIndex = reqIndex[k*INDEX_WIDTH +: INDEX_WIDTH];
            selData  = reqData[k*DATA_W +: DATA_W];
         end
      end
      header = '0;
      header[MAGIC_START_BIT +: MAGIC_WIDTH] = expectedHeaderMagic;
      header[INDEX_START_BIT +: INDEX_WIDTH] = selIndex;
   end

   // The word that follows the one currently on TDATA, taken from the payload
   // latched at grant time, plus whether that word closes the packet.
   always_comb begin
      nextWord = '0;
      for (int w = 0; w < NUM_DATA_WORDS; w++) begin
         if (int'(wordCnt) + 1 == w) begin
            nextWord = dataLatch[w*32 +: 32];
         end
      end
      nextIsLast = (int'(wordCnt) + 1 == NUM_DATA_WORDS - 1);
   end

   // Next-state and output logic. Every register holds by default; reqAck and
   // cycleDoneStrobe default low so they are single-cycle pulses. The cycle
   // strobe is applied last so it overrides a sentMask update from a packet
   // finishing on the same edge, while that packet still gets counted.
   always_comb begin
      stateNext       = state;
      rrPtrNext       = rrPtr;
      grantIdNext     = grantId;
      wordCntNext     = wordCnt;
      dataLatchNext   = dataLatch;
      tvalidNext      = TVALID;
      tlastNext       = TLAST;
      tdataNext       = TDATA;
      reqAckNext      = '0;
      sentMaskNext    = sentMask;
      packetCountNext = packetCount;
      cycleDoneNext   = 1'b0;

      case (state)
         S_IDLE: begin
            if (!newCycleStrobe && grantFound) begin
               reqAckNext    = NUM_REQ'(1) << grantSel;
               dataLatchNext = selData;
               grantIdNext   = grantSel;
               rrPtrNext     = (int'(grantSel) == NUM_REQ - 1) ? '0 : grantSel + PTR_W'(1);
               tvalidNext    = 1'b1;
               tdataNext     = header;
               tlastNext     = 1'b0;
               stateNext     = S_HEADER;
            end
         end
         S_HEADER: begin
            if (handshake) begin
               tdataNext   = dataLatch[31:0];
               tlastNext   = (NUM_DATA_WORDS == 1);
               wordCntNext = '0;
               stateNext   = S_DATA;
            end
         end
         S_DATA: begin
            if (handshake) begin
               if (TLAST) begin
                  tvalidNext      = 1'b0;
                  tlastNext       = 1'b0;
                  stateNext       = S_IDLE;
                  sentMaskNext    = sentMask | (NUM_REQ'(1) << grantId);
                  packetCountNext = packetCount + 16'd1;
               end else begin
                  tdataNext   = nextWord;
                  wordCntNext = wordCnt + CNT_W'(1);
                  tlastNext   = nextIsLast;
               end
            end
         end
         default: begin
            stateNext = S_IDLE;
         end
      endcase

      if (newCycleStrobe) begin
         sentMaskNext = '0;
         rrPtrNext    = '0;
      end

      cycleDoneNext = (&sentMaskNext) && !(&sentMask);
   end

   // State and output registers. Reset is synchronous; a reset mid-packet
   // simply drops TVALID and leaves the truncated packet for the receiver to
   // reject on size.
   always_ff @(posedge auroraClk) begin
      if (auroraReset) begin
         state           <= S_IDLE;
         rrPtr           <= '0;
         grantId         <= '0;
         wordCnt         <= '0;
         dataLatch       <= '0;
         TVALID          <= 1'b0;
         TLAST           <= 1'b0;
         TDATA           <= '0;
         reqAck          <= '0;
         sentMask        <= '0;
         cycleDoneStrobe <= 1'b0;
         packetCount     <= '0;
      end else begin
         state           <= stateNext;
         rrPtr           <= rrPtrNext;
         grantId         <= grantIdNext;
         wordCnt         <= wordCntNext;
         dataLatch       <= dataLatchNext;
         TVALID          <= tvalidNext;
         TLAST           <= tlastNext;
         TDATA           <= tdataNext;
         reqAck          <= reqAckNext;
         sentMask        <= sentMaskNext;
         cycleDoneStrobe <= cycleDoneNext;
         packetCount     <= packetCountNext;
      end
   end

endmodule
